rv32i_core: RTL and testbench
=============================

Name: rv32i_core

Overview:
- Single-cycle RV32I integer core; one instruction fetched, executed and retired per rising clock edge.
- Self-contained top: internal word-addressed instruction memory, data memory and 32x32 register file; only external pins are clock and reset.
- Top-level compute block of the processor; benches preload the memories and registers and probe internal state by hierarchical name.

Parameters:
- MEM_WORDS, 1024, depth in 32-bit words of each memory (instruction and data).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Required internal names (benches probe these):
  - pc: PC register.
  - pc_in: next-PC.
  - instruction_mux_out: current instruction.
  - mux_a_out / mux_b_out: ALU operands.
  - alu_out: ALU result.
  - register_file.regFile[0:31]: register array.
  - insn_memory.mem[0:MEM_WORDS-1] and data_memory.mem[0:MEM_WORDS-1]: memory arrays.
  - All arrays must be writable by bench initialisation.
- Reset: at a rising edge with reset=1, pc <= RESET_PC. No register, memory or data write happens that cycle. Register file and memories are not cleared.
- Fetch: instruction = insn_memory.mem[pc[11:2]], combinational. pc[1:0] are ignored.
- Register file: two combinational read ports and one write port, written on the rising edge.
  - Reads of x0 return 0.
  - Writes to x0 are discarded.
  - A read of a register written in the same cycle returns the old value.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LW, SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- Immediates are sign-extended per the I/S/B/U/J formats.
- ALU rules:
  - Shifts use shamt = operand_b[4:0].
  - SRL fills with zeros; SRA fills with bit 31.
  - SUB and SRA are selected by funct7[5] = 1 (for SRAI, imm[10] = 1).
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - Add/sub wrap modulo 2^32; no overflow trap.
- Operand muxes:
  - mux_a_out = pc for AUIPC/JAL; 0 for LUI; rs1 otherwise.
  - mux_b_out = rs2 for R-type and branches; immediate otherwise.
- Next PC (default pc_in = pc+4):
  - Taken branch: pc+immB.
  - JAL: pc+immJ.
  - JALR: (rs1+immI) & ~1.
- JAL/JALR write pc+4 to rd.
- LW: rd <= data_memory.mem[addr[11:2]], where addr = rs1+immI.
- SW: data_memory.mem[addr[11:2]] <= rs2 on the rising edge. Data read is combinational.
- Address bits above [11:2] are ignored, so addresses wrap modulo 4 KiB.
- Misaligned access uses the word at addr[11:2]; no trap.
- Unsupported opcodes/funct3 (including byte/half loads and stores, FENCE, SYSTEM) execute as NOP: no register or memory write, pc <= pc+4.
- PC wrap: pc+4 wraps modulo 2^32; fetch wraps modulo MEM_WORDS.
- Reset asserted mid-program: any write of the current instruction is suppressed and pc returns to RESET_PC on that edge.

Test Plan:
- Preload regFile[k]=k. Run mem[0]=ADDI x1,x1,52; mem[1]=ADDI x2,x1,4; mem[2]=SRL x3,x1,x2 with reset low.
  -> x1=53, x2=57, x3=53>>25=0 after three edges; pc=12.
- x1=0x8000_0000, x2=4; SRA x3,x1,x2 and SRL x4,x1,x2.
  -> x3=0xF800_0000, x4=0x0800_0000.
- ADDI x0,x0,5; ADD x5,x0,x0.
  -> regFile[0] unchanged, x5=0; SUB x6,x1,x2 with x1=1, x2=2 -> x6=0xFFFF_FFFF.
- SW x2,8(x0) with x2=0x1234; then LW x7,8(x0).
  -> data_memory.mem[2]=0x1234, x7=0x1234.
- BEQ x1,x1,+8 at pc=0.
  -> pc=8; BNE x1,x1,+8 -> pc+4.
  - JAL x1,+16 at pc=4 -> x1=8, pc=20.
  - JALR x0,3(x2) with x2=0x40 -> pc=0x42.
- Hold reset=1 for two edges mid-program.
  -> pc=0, no register/memory changes during reset.
  - Execution resumes from mem[0] after reset deasserts.

Source files
------------

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute and retire one instruction per clock.
// Instruction memory, data memory and register file are internal and preloadable by hierarchy.

module rv32i_mem #(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [0:WORDS-1];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module rv32i_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regFile [0:31];

  always_ff @(posedge clk)
    if (we && wa != 5'd0) regFile[wa] <= wd;

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regFile[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regFile[ra2];
endmodule

module rv32i_core #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND
  } alu_op_t;
  typedef enum logic [1:0] {WB_ALU, WB_PC4, WB_MEM} wb_t;

  logic [31:0] pc, pc_in, instruction_mux_out, mux_a_out, mux_b_out, alu_out;
  logic [31:0] rs1_data, rs2_data, mem_rdata, wb_data, imm, pc_plus4;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        a_pc, a_zero, b_rs2, reg_we, mem_we, branch, jal, jalr, take;
  alu_op_t     alu_op;
  wb_t         wb_sel;

  rv32i_mem #(.WORDS(MEM_WORDS)) insn_memory (
    .clk(clk), .we(1'b0), .addr(pc[AW+1:2]), .wdata(32'd0), .rdata(instruction_mux_out)
  );

  rv32i_mem #(.WORDS(MEM_WORDS)) data_memory (
    .clk(clk), .we(mem_we && !reset), .addr(alu_out[AW+1:2]), .wdata(rs2_data), .rdata(mem_rdata)
  );

  rv32i_regfile register_file (
    .clk(clk), .we(reg_we && !reset),
    .ra1(instruction_mux_out[19:15]), .ra2(instruction_mux_out[24:20]),
    .wa(instruction_mux_out[11:7]), .wd(wb_data), .rd1(rs1_data), .rd2(rs2_data)
  );

  assign opcode = instruction_mux_out[6:0];
  assign funct3 = instruction_mux_out[14:12];
  assign imm_i  = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
  assign imm_s  = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:25], instruction_mux_out[11:7]};
  assign imm_b  = {{19{instruction_mux_out[31]}}, instruction_mux_out[31], instruction_mux_out[7],
                   instruction_mux_out[30:25], instruction_mux_out[11:8], 1'b0};
  assign imm_u  = {instruction_mux_out[31:12], 12'd0};
  assign imm_j  = {{11{instruction_mux_out[31]}}, instruction_mux_out[31], instruction_mux_out[19:12],
                   instruction_mux_out[20], instruction_mux_out[30:21], 1'b0};

  // Subtract is only legal on register-register ops; bit 30 also selects arithmetic right shift.
  function automatic alu_op_t f3_op(input logic [2:0] f3, input logic alt, input logic sub_ok);
    case (f3)
      3'd0:    return (alt && sub_ok) ? A_SUB : A_ADD;
      3'd1:    return A_SLL;
      3'd2:    return A_SLT;
      3'd3:    return A_SLTU;
      3'd4:    return A_XOR;
      3'd5:    return alt ? A_SRA : A_SRL;
      3'd6:    return A_OR;
      default: return A_AND;
    endcase
  endfunction

  always_comb begin
    alu_op = A_ADD; imm = imm_i; wb_sel = WB_ALU;
    a_pc = 1'b0; a_zero = 1'b0; b_rs2 = 1'b0;
    reg_we = 1'b0; mem_we = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0;
    case (opcode)
      7'b0110111: begin a_zero = 1'b1; imm = imm_u; reg_we = 1'b1; end
      7'b0010111: begin a_pc = 1'b1; imm = imm_u; reg_we = 1'b1; end
      7'b1101111: begin a_pc = 1'b1; imm = imm_j; reg_we = 1'b1; wb_sel = WB_PC4; jal = 1'b1; end
      7'b1100111: if (funct3 == 3'd0) begin reg_we = 1'b1; wb_sel = WB_PC4; jalr = 1'b1; end
      7'b1100011: begin b_rs2 = 1'b1; imm = imm_b; branch = (funct3 != 3'd2) && (funct3 != 3'd3); end
      7'b0000011: if (funct3 == 3'd2) begin reg_we = 1'b1; wb_sel = WB_MEM; end
      7'b0100011: if (funct3 == 3'd2) begin imm = imm_s; mem_we = 1'b1; end
      7'b0010011: begin reg_we = 1'b1; alu_op = f3_op(funct3, instruction_mux_out[30], 1'b0); end
      7'b0110011: begin
        b_rs2 = 1'b1; reg_we = 1'b1; alu_op = f3_op(funct3, instruction_mux_out[30], 1'b1);
      end
      default: ;
    endcase
  end

  assign mux_a_out = a_zero ? 32'd0 : (a_pc ? pc : rs1_data);
  assign mux_b_out = b_rs2 ? rs2_data : imm;

  always_comb begin
    case (alu_op)
      A_SUB:   alu_out = mux_a_out - mux_b_out;
      A_SLL:   alu_out = mux_a_out << mux_b_out[4:0];
      A_SLT:   alu_out = {31'd0, $signed(mux_a_out) < $signed(mux_b_out)};
      A_SLTU:  alu_out = {31'd0, mux_a_out < mux_b_out};
      A_XOR:   alu_out = mux_a_out ^ mux_b_out;
      A_SRL:   alu_out = mux_a_out >> mux_b_out[4:0];
      A_SRA:   alu_out = $signed(mux_a_out) >>> mux_b_out[4:0];
      A_OR:    alu_out = mux_a_out | mux_b_out;
      A_AND:   alu_out = mux_a_out & mux_b_out;
      default: alu_out = mux_a_out + mux_b_out;
    endcase
  end

  always_comb begin
    case (funct3)
      3'd0:    take = rs1_data == rs2_data;
      3'd1:    take = rs1_data != rs2_data;
      3'd4:    take = $signed(rs1_data) <  $signed(rs2_data);
      3'd5:    take = $signed(rs1_data) >= $signed(rs2_data);
      3'd6:    take = rs1_data <  rs2_data;
      3'd7:    take = rs1_data >= rs2_data;
      default: take = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_in = pc_plus4;
    if (jal)                 pc_in = alu_out;
    else if (jalr)           pc_in = {alu_out[31:1], 1'b0};
    else if (branch && take) pc_in = pc + imm;
  end

  always_comb begin
    case (wb_sel)
      WB_PC4:  wb_data = pc_plus4;
      WB_MEM:  wb_data = mem_rdata;
      default: wb_data = alu_out;
    endcase
  end

  always_ff @(posedge clk)
    if (reset) pc <= RESET_PC;
    else       pc <= pc_in;
endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: directed scenarios plus random programs checked against an
// instruction-level model that executes symbolic instructions rather than decoding bits.
module tb_rv32i_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  rv32i_core #(.MEM_WORDS(1024), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  typedef enum int {
    I_LUI, I_AUIPC, I_JAL, I_JALR, I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU, I_LW, I_SW,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
    I_LB, I_FENCE, I_ECALL, I_NUM
  } op_e;

  typedef struct {
    op_e op;
    int  rd;
    int  rs1;
    int  rs2;
    int  imm;
  } ins_t;

  ins_t        prog [1024];
  logic [31:0] m_reg [32];
  logic [31:0] m_dmem [1024];
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input ins_t x);
    logic [31:0] im = x.imm;
    logic [4:0] rd = x.rd[4:0];
    logic [4:0] r1 = x.rs1[4:0];
    logic [4:0] r2 = x.rs2[4:0];
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = 3'd0; f7 = 7'd0;
    case (x.op)
      I_BNE, I_SLL, I_SLLI: f3 = 3'd1;
      I_SLT, I_SLTI, I_LW, I_SW: f3 = 3'd2;
      I_SLTU, I_SLTIU: f3 = 3'd3;
      I_BLT, I_XOR, I_XORI: f3 = 3'd4;
      I_BGE, I_SRL, I_SRA, I_SRLI, I_SRAI: f3 = 3'd5;
      I_BLTU, I_OR, I_ORI: f3 = 3'd6;
      I_BGEU, I_AND, I_ANDI: f3 = 3'd7;
      default: f3 = 3'd0;
    endcase
    if (x.op == I_SUB || x.op == I_SRA || x.op == I_SRAI) f7 = 7'h20;
    case (x.op)
      I_LUI:   return {im[19:0], rd, 7'h37};
      I_AUIPC: return {im[19:0], rd, 7'h17};
      I_JAL:   return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
      I_JALR:  return {im[11:0], r1, 3'd0, rd, 7'h67};
      I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU:
               return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
      I_LW:    return {im[11:0], r1, f3, rd, 7'h03};
      I_SW:    return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
      I_SLLI, I_SRLI, I_SRAI: return {f7, im[4:0], r1, f3, rd, 7'h13};
      I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI: return {im[11:0], r1, f3, rd, 7'h13};
      I_LB:    return {im[11:0], r1, 3'd0, rd, 7'h03};
      I_FENCE: return 32'h0ff0000f;
      I_ECALL: return 32'h00000073;
      default: return {f7, r2, r1, f3, rd, 7'h33};
    endcase
  endfunction

  // Executes one symbolic instruction on the model state.
  task automatic exec(input ins_t x);
    logic [31:0] a, b, im, res, npc, ea;
    bit wr;
    a = m_reg[x.rs1]; b = m_reg[x.rs2]; im = x.imm;
    npc = m_pc + 4; wr = 1'b1; res = 32'd0;
    ea = a + im;
    case (x.op)
      I_LUI:   res = im << 12;
      I_AUIPC: res = m_pc + (im << 12);
      I_JAL:   begin res = m_pc + 4; npc = m_pc + im; end
      I_JALR:  begin res = m_pc + 4; npc = ea & ~32'd1; end
      I_BEQ:   begin wr = 0; if (a == b) npc = m_pc + im; end
      I_BNE:   begin wr = 0; if (a != b) npc = m_pc + im; end
      I_BLT:   begin wr = 0; if ($signed(a) < $signed(b)) npc = m_pc + im; end
      I_BGE:   begin wr = 0; if ($signed(a) >= $signed(b)) npc = m_pc + im; end
      I_BLTU:  begin wr = 0; if (a < b) npc = m_pc + im; end
      I_BGEU:  begin wr = 0; if (a >= b) npc = m_pc + im; end
      I_LW:    res = m_dmem[(ea >> 2) % 1024];
      I_SW:    begin wr = 0; m_dmem[(ea >> 2) % 1024] = b; end
      I_ADDI:  res = a + im;
      I_SLTI:  res = ($signed(a) < $signed(im)) ? 1 : 0;
      I_SLTIU: res = (a < im) ? 1 : 0;
      I_XORI:  res = a ^ im;
      I_ORI:   res = a | im;
      I_ANDI:  res = a & im;
      I_SLLI:  res = a << x.imm;
      I_SRLI:  res = a >> x.imm;
      I_SRAI:  res = $signed(a) >>> x.imm;
      I_ADD:   res = a + b;
      I_SUB:   res = a - b;
      I_SLL:   res = a << (b % 32);
      I_SLT:   res = ($signed(a) < $signed(b)) ? 1 : 0;
      I_SLTU:  res = (a < b) ? 1 : 0;
      I_XOR:   res = a ^ b;
      I_SRL:   res = a >> (b % 32);
      I_SRA:   res = $signed(a) >>> (b % 32);
      I_OR:    res = a | b;
      I_AND:   res = a & b;
      default: wr = 0;
    endcase
    if (wr && x.rd != 0) m_reg[x.rd] = res;
    m_pc = npc;
  endtask

  function automatic ins_t rand_ins();
    ins_t x;
    x.op = op_e'($urandom_range(0, I_NUM - 1));
    x.rd = $urandom_range(0, 31); x.rs1 = $urandom_range(0, 31); x.rs2 = $urandom_range(0, 31);
    case (x.op)
      I_LUI, I_AUIPC:          x.imm = $urandom_range(0, 32'hfffff);
      I_JAL:                   x.imm = (int'($urandom_range(0, 32'hfffff)) - 32'h80000) * 2;
      I_SLLI, I_SRLI, I_SRAI:  x.imm = $urandom_range(0, 31);
      I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU:
                               x.imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      default:                 x.imm = int'($urandom_range(0, 4095)) - 2048;
    endcase
    return x;
  endfunction

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset over one edge, then fills the program with NOPs and regs with x[k]=k.
  task automatic boot();
    reset = 1'b1;
    run(1);
    for (int i = 0; i < 1024; i++) dut.insn_memory.mem[i] = 32'h0000_0013;
    for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = k;
  endtask

  task automatic load(input int idx, input ins_t x);
    dut.insn_memory.mem[idx] = enc(x);
  endtask

  initial begin
    // Arithmetic chain and reset state
    boot();
    chk("reset_pc", dut.pc, 32'h0);
    load(0, '{I_ADDI, 1, 1, 0, 52});
    load(1, '{I_ADDI, 2, 1, 0, 4});
    load(2, '{I_SRL, 3, 1, 2, 0});
    reset = 1'b0; run(3);
    chk("chain_x1", dut.register_file.regFile[1], 32'd53);
    chk("chain_x2", dut.register_file.regFile[2], 32'd57);
    chk("chain_x3", dut.register_file.regFile[3], 32'd0);
    chk("chain_pc", dut.pc, 32'd12);

    // Arithmetic vs logical right shift of a negative value
    boot();
    dut.register_file.regFile[1] = 32'h8000_0000; dut.register_file.regFile[2] = 32'd4;
    load(0, '{I_SRA, 3, 1, 2, 0});
    load(1, '{I_SRL, 4, 1, 2, 0});
    reset = 1'b0; run(2);
    chk("sra", dut.register_file.regFile[3], 32'hF800_0000);
    chk("srl", dut.register_file.regFile[4], 32'h0800_0000);

    // x0 stays zero; SUB wraps
    boot();
    dut.register_file.regFile[1] = 32'd1; dut.register_file.regFile[2] = 32'd2;
    load(0, '{I_ADDI, 0, 0, 0, 5});
    load(1, '{I_ADD, 5, 0, 0, 0});
    load(2, '{I_SUB, 6, 1, 2, 0});
    reset = 1'b0; run(3);
    chk("x0_kept", dut.register_file.regFile[0], 32'd0);
    chk("add_x0", dut.register_file.regFile[5], 32'd0);
    chk("sub_wrap", dut.register_file.regFile[6], 32'hFFFF_FFFF);

    // Store then load
    boot();
    dut.register_file.regFile[2] = 32'h1234;
    load(0, '{I_SW, 0, 0, 2, 8});
    load(1, '{I_LW, 7, 0, 0, 8});
    reset = 1'b0; run(2);
    chk("sw_mem", dut.data_memory.mem[2], 32'h1234);
    chk("lw_x7", dut.register_file.regFile[7], 32'h1234);

    // Branches
    boot();
    load(0, '{I_BEQ, 0, 1, 1, 8});
    load(2, '{I_BNE, 0, 1, 1, 8});
    reset = 1'b0; run(1);
    chk("beq_pc", dut.pc, 32'd8);
    run(1);
    chk("bne_pc", dut.pc, 32'd12);

    // JAL
    boot();
    load(1, '{I_JAL, 1, 0, 0, 16});
    reset = 1'b0; run(2);
    chk("jal_link", dut.register_file.regFile[1], 32'd8);
    chk("jal_pc", dut.pc, 32'd20);

    // JALR clears bit 0 of the target
    boot();
    dut.register_file.regFile[2] = 32'h40;
    load(0, '{I_JALR, 0, 2, 0, 3});
    reset = 1'b0; run(1);
    chk("jalr_pc", dut.pc, 32'h42);

    // Reset held for two edges mid-program suppresses writes
    boot();
    dut.register_file.regFile[1] = 32'd0;
    dut.data_memory.mem[1] = 32'hDEAD;
    load(0, '{I_ADDI, 1, 1, 0, 1});
    load(1, '{I_SW, 0, 0, 1, 4});
    load(2, '{I_ADDI, 1, 1, 0, 1});
    reset = 1'b0; run(1);
    chk("mid_pc0", dut.pc, 32'd4);
    reset = 1'b1; run(1);
    chk("mid_rst1_pc", dut.pc, 32'd0);
    chk("mid_rst1_mem", dut.data_memory.mem[1], 32'hDEAD);
    run(1);
    chk("mid_rst2_pc", dut.pc, 32'd0);
    chk("mid_rst2_x1", dut.register_file.regFile[1], 32'd1);
    reset = 1'b0; run(1);
    chk("resume_x1", dut.register_file.regFile[1], 32'd2);
    run(1);
    chk("resume_mem", dut.data_memory.mem[1], 32'd2);
    chk("resume_pc", dut.pc, 32'd8);

    // Random programs against the model
    for (int r = 0; r < 3; r++) begin
      reset = 1'b1; run(1);
      for (int i = 0; i < 1024; i++) begin
        prog[i] = rand_ins();
        dut.insn_memory.mem[i] = enc(prog[i]);
        m_dmem[i] = $urandom;
        dut.data_memory.mem[i] = m_dmem[i];
      end
      for (int k = 0; k < 32; k++) begin
        m_reg[k] = (k == 0) ? 32'd0 : ((k < 8) ? 32'($urandom_range(0, 4095)) : $urandom);
        dut.register_file.regFile[k] = m_reg[k];
      end
      m_pc = 32'h0;
      reset = 1'b0;
      for (int c = 0; c < 600; c++) begin
        exec(prog[m_pc[11:2]]);
        run(1);
        chk($sformatf("rnd%0d_pc_c%0d", r, c), dut.pc, m_pc);
        if (c % 4 == 3)
          for (int k = 0; k < 32; k++)
            chk($sformatf("rnd%0d_x%0d_c%0d", r, k, c), dut.register_file.regFile[k], m_reg[k]);
      end
      for (int i = 0; i < 1024; i++)
        chk($sformatf("rnd%0d_dmem%0d", r, i), dut.data_memory.mem[i], m_dmem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
